// File: rtl/qea_pkg.sv
// rtl/qea_pkg.sv - shared QEA state-RAM constants, reader FSM states and word-count helper
package qea_pkg;

    localparam int PE_NUM_WIDTH     = 2;
    localparam int PE_NUM           = 1 << PE_NUM_WIDTH;
    localparam int DATA_WIDTH       = 32;
    localparam int STATE_DATA_WIDTH = DATA_WIDTH * 2;
    localparam int STATE_WORD_WIDTH = PE_NUM * STATE_DATA_WIDTH;
    localparam int STATE_ADDR_WIDTH = 16;
    localparam int MAX_QBIT_WIDTH   = 6;

    localparam logic [MAX_QBIT_WIDTH-1:0]   QBIT_MIN  = MAX_QBIT_WIDTH'(2);
    localparam logic [MAX_QBIT_WIDTH-1:0]   QBIT_FULL = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
    localparam logic [STATE_ADDR_WIDTH:0]   WORD_ONE  = (STATE_ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_READ,
        RD_WAIT,
        RD_SEND,
        RD_DONE
    } rd_state_t;

    // Index of the final word (N-1); the extra bit lets N reach 2^STATE_ADDR_WIDTH
    function automatic logic [STATE_ADDR_WIDTH:0] last_word_addr(input logic [MAX_QBIT_WIDTH-1:0] qbit);
        logic [STATE_ADDR_WIDTH:0] n;
        if (qbit < QBIT_MIN) begin
            n = WORD_ONE;
        end else if (qbit >= QBIT_FULL) begin
            n = WORD_ONE << STATE_ADDR_WIDTH;
        end else begin
            n = WORD_ONE << (qbit - QBIT_MIN);
        end
        return n - WORD_ONE;
    endfunction

endpackage

// File: rtl/qea_word_serializer.sv
// rtl/qea_word_serializer.sv - holds one state-RAM word and emits it one lane per valid/ready beat
module qea_word_serializer
    import qea_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_load,
    input  logic [STATE_WORD_WIDTH-1:0] i_word,
    input  logic [STATE_ADDR_WIDTH-1:0] i_addr,
    input  logic                        i_last_word,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [STATE_DATA_WIDTH-1:0] o_data,
    output logic [STATE_ADDR_WIDTH-1:0] o_addr,
    output logic [PE_NUM_WIDTH-1:0]     o_lane,
    output logic                        o_last,
    output logic                        o_word_done
);

    localparam logic [PE_NUM_WIDTH-1:0] LANE_LAST = PE_NUM_WIDTH'(PE_NUM - 1);

    logic [STATE_WORD_WIDTH-1:0] r_hold;
    logic [STATE_ADDR_WIDTH-1:0] r_addr;
    logic [PE_NUM_WIDTH-1:0]     r_lane;
    logic                        r_valid;
    logic                        r_last_word;
    logic                        w_fire;
    logic [STATE_DATA_WIDTH-1:0] w_data;

    assign w_fire      = r_valid && i_ready;
    assign o_word_done = w_fire && (r_lane == LANE_LAST);

    // Load a freshly read word, then step lanes only on a handshake so everything holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_addr      <= '0;
            r_lane      <= '0;
            r_valid     <= 1'b0;
            r_last_word <= 1'b0;
        end else if (i_load) begin
            r_hold      <= i_word;
            r_addr      <= i_addr;
            r_lane      <= '0;
            r_valid     <= 1'b1;
            r_last_word <= i_last_word;
        end else if (w_fire) begin
            if (r_lane == LANE_LAST) begin
                r_valid <= 1'b0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    // Lane 0 is the most-significant amplitude slice of the word
    always_comb begin
        w_data = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            if (r_lane == PE_NUM_WIDTH'(k)) begin
                w_data = r_hold[(PE_NUM - k) * STATE_DATA_WIDTH - 1 -: STATE_DATA_WIDTH];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = w_data;
    assign o_addr  = r_addr;
    assign o_lane  = r_lane;
    assign o_last  = r_valid && r_last_word && (r_lane == LANE_LAST);

endmodule

// File: rtl/qea_state_reader.sv
// rtl/qea_state_reader.sv - sweeps the QEA state RAM and streams every amplitude out on valid/ready
module qea_state_reader
    import qea_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]   i_qbit_num,
    output logic                        o_state_ena,
    output logic                        o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0] o_state_addra,
    input  logic [STATE_WORD_WIDTH-1:0] i_state_dout,
    output logic                        o_amp_valid,
    input  logic                        i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0] o_amp_data,
    output logic [STATE_ADDR_WIDTH-1:0] o_amp_addr,
    output logic [PE_NUM_WIDTH-1:0]     o_amp_lane,
    output logic                        o_amp_last,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    rd_state_t                   r_state;
    logic [STATE_ADDR_WIDTH:0]   r_addr;
    logic [STATE_ADDR_WIDTH:0]   r_last_addr;
    logic [1:0]                  r_lat_cnt;
    logic                        r_state_ena;
    logic [STATE_ADDR_WIDTH-1:0] r_state_addra;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_load;
    logic                        w_last_word;
    logic                        w_word_done;
    logic [STATE_ADDR_WIDTH:0]   w_addr_next;

    assign w_load      = (r_state == RD_WAIT) && (r_lat_cnt == LAT_LAST);
    assign w_last_word = (r_addr == r_last_addr);
    assign w_addr_next = r_addr + WORD_ONE;

    // Sweep sequencer: one read per word, wait out the RAM latency, then let the serializer drain it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RD_IDLE;
            r_addr        <= '0;
            r_last_addr   <= '0;
            r_lat_cnt     <= '0;
            r_state_ena   <= 1'b0;
            r_state_addra <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state_ena <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    if (i_start) begin
                        r_last_addr   <= last_word_addr(i_qbit_num);
                        r_addr        <= '0;
                        r_state_ena   <= 1'b1;
                        r_state_addra <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= RD_READ;
                    end
                end
                RD_READ: begin
                    r_lat_cnt <= '0;
                    r_state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_state <= RD_SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                RD_SEND: begin
                    if (w_word_done) begin
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= RD_DONE;
                        end else begin
                            r_addr        <= w_addr_next;
                            r_state_ena   <= 1'b1;
                            r_state_addra <= w_addr_next[STATE_ADDR_WIDTH-1:0];
                            r_state       <= RD_READ;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

    qea_word_serializer u_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_word      (i_state_dout),
        .i_addr      (r_addr[STATE_ADDR_WIDTH-1:0]),
        .i_last_word (w_last_word),
        .i_ready     (i_amp_ready),
        .o_valid     (o_amp_valid),
        .o_data      (o_amp_data),
        .o_addr      (o_amp_addr),
        .o_lane      (o_amp_lane),
        .o_last      (o_amp_last),
        .o_word_done (w_word_done)
    );

    assign o_state_ena   = r_state_ena;
    assign o_state_wea   = 1'b0;
    assign o_state_addra = r_state_addra;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_qea_state_reader.sv
// tb/tb_qea_state_reader.sv - randomized scoreboard bench for qea_state_reader at read latency 1 and 3
module tb_qea_state_reader;
    import qea_pkg::*;

    localparam int NI = 2;
    localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [5:0] i_qbit_num = '0;
    logic       i_amp_ready = 1'b1;

    logic         state_ena   [NI];
    logic         state_wea   [NI];
    logic [15:0]  state_addra [NI];
    logic [255:0] state_dout  [NI];
    logic         amp_valid   [NI];
    logic [63:0]  amp_data    [NI];
    logic [15:0]  amp_addr    [NI];
    logic [1:0]   amp_lane    [NI];
    logic         amp_last    [NI];
    logic         busy        [NI];
    logic         done        [NI];

    qea_state_reader #(.RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .o_state_ena(state_ena[0]), .o_state_wea(state_wea[0]), .o_state_addra(state_addra[0]),
        .i_state_dout(state_dout[0]), .o_amp_valid(amp_valid[0]), .i_amp_ready(i_amp_ready),
        .o_amp_data(amp_data[0]), .o_amp_addr(amp_addr[0]), .o_amp_lane(amp_lane[0]),
        .o_amp_last(amp_last[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    qea_state_reader #(.RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .o_state_ena(state_ena[1]), .o_state_wea(state_wea[1]), .o_state_addra(state_addra[1]),
        .i_state_dout(state_dout[1]), .o_amp_valid(amp_valid[1]), .i_amp_ready(i_amp_ready),
        .o_amp_data(amp_data[1]), .o_amp_addr(amp_addr[1]), .o_amp_lane(amp_lane[1]),
        .o_amp_last(amp_last[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    always #5 clk = ~clk;

    // State RAM shared by both instances, each with its own read pipeline
    logic [255:0] mem [0:65535];
    logic [255:0] p0, p1a, p1b, p1c;
    always @(posedge clk) begin
        p0  <= state_ena[0] ? mem[state_addra[0]] : JUNK;
        p1a <= state_ena[1] ? mem[state_addra[1]] : JUNK;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign state_dout[0] = p0;
    assign state_dout[1] = p1c;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input int j, input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", j, name, act, exp, $time);
    endtask

    function automatic int words_of(input int q);
        if (q < 2) return 1;
        if (q - 2 >= 16) return 65536;
        return 1 << (q - 2);
    endfunction

    // Inputs as the DUT saw them at the last rising edge
    int         cyc = 0;
    logic       st_smp = 1'b0, rdy_smp = 1'b0, rst_smp = 1'b0;
    logic [5:0] q_smp = '0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        st_smp  <= i_start;
        rdy_smp <= i_amp_ready;
        rst_smp <= rst;
        q_smp   <= i_qbit_num;
    end

    // Scoreboard state: phase 0 idle, 1 streaming, 2 done cycle
    int          phase [NI] = '{0, 0};
    int          k     [NI] = '{0, 0};
    int          nw    [NI] = '{1, 1};
    int          c0    [NI] = '{0, 0};
    int          hs_cnt[NI] = '{0, 0};
    int          rd_cnt[NI] = '{0, 0};
    int          done_cnt[NI] = '{0, 0};
    bit          seen_first[NI] = '{0, 0};
    bit          all_rdy[NI] = '{1, 1};
    bit          prev_valid[NI] = '{0, 0};
    logic [63:0] prev_data[NI];
    logic [15:0] prev_addr[NI];
    logic [1:0]  prev_lane[NI];
    logic [63:0] first_data[NI];
    logic [15:0] last_hs_addr[NI];
    logic [1:0]  last_hs_lane[NI];

    int           lat_v, ea, el;
    logic [255:0] w_v;
    logic [63:0]  ed;

    always @(negedge clk) begin
        for (int j = 0; j < NI; j++) begin
            lat_v = (j == 0) ? 1 : 3;
            if (rst_smp) begin
                phase[j] = 0;
            end else begin
                case (phase[j])
                    0: if (st_smp) begin
                        phase[j] = 1; k[j] = 0; nw[j] = words_of(int'(q_smp)); c0[j] = cyc - 1;
                        hs_cnt[j] = 0; rd_cnt[j] = 0; seen_first[j] = 0; all_rdy[j] = 1;
                    end
                    1: if (prev_valid[j] && rdy_smp) begin
                        if (k[j] == 0) first_data[j] = prev_data[j];
                        last_hs_addr[j] = prev_addr[j];
                        last_hs_lane[j] = prev_lane[j];
                        hs_cnt[j]++;
                        k[j]++;
                        if (k[j] == nw[j] * PE_NUM) phase[j] = 2;
                    end else if (prev_valid[j]) begin
                        all_rdy[j] = 0;
                    end
                    default: phase[j] = 0;
                endcase
            end

            chk(j, "wea", state_wea[j], 0);
            chk(j, "busy", busy[j], phase[j] != 0);
            chk(j, "done", done[j], phase[j] == 2);
            if (done[j]) begin
                done_cnt[j]++;
                if (all_rdy[j]) chk(j, "sweep_cycles", cyc - c0[j], nw[j] * (PE_NUM + 1 + lat_v) + 1);
            end
            if (state_ena[j]) begin
                chk(j, "rd_addr", state_addra[j], rd_cnt[j]);
                rd_cnt[j]++;
            end
            if (phase[j] != 1) begin
                chk(j, "valid_idle", amp_valid[j], 0);
                chk(j, "ena_idle", state_ena[j], 0);
            end
            if (!rst_smp && prev_valid[j] && !rdy_smp) begin
                chk(j, "hold_valid", amp_valid[j], 1);
                chk(j, "hold_data", amp_data[j], prev_data[j]);
                chk(j, "hold_addr", amp_addr[j], prev_addr[j]);
                chk(j, "hold_lane", amp_lane[j], prev_lane[j]);
            end
            if (phase[j] == 1 && amp_valid[j]) begin
                ea  = k[j] / PE_NUM;
                el  = k[j] % PE_NUM;
                w_v = mem[16'(ea)];
                ed  = w_v[(PE_NUM - el) * 64 - 1 -: 64];
                chk(j, "data", amp_data[j], ed);
                chk(j, "addr", amp_addr[j], ea);
                chk(j, "lane", amp_lane[j], el);
                chk(j, "last", amp_last[j], k[j] == nw[j] * PE_NUM - 1);
                if (!seen_first[j]) begin
                    seen_first[j] = 1;
                    chk(j, "first_valid_lat", cyc - c0[j], 2 + lat_v);
                end
            end
            prev_valid[j] = amp_valid[j];
            prev_data[j]  = amp_data[j];
            prev_addr[j]  = amp_addr[j];
            prev_lane[j]  = amp_lane[j];
        end
    end

    bit rand_rdy = 0;

    task automatic tick();
        @(negedge clk);
        i_amp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic start_sweep(input logic [5:0] q);
        tick();
        i_qbit_num = q;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_beats, input int exp_words);
        int d[NI];
        int n;
        for (int j = 0; j < NI; j++) d[j] = done_cnt[j];
        n = 0;
        while ((done_cnt[0] == d[0] || done_cnt[1] == d[1]) && n < budget) begin
            tick();
            n++;
        end
        chk(0, "done_within_budget", n < budget, 1);
        repeat (4) tick();
        for (int j = 0; j < NI; j++) begin
            chk(j, "done_once", done_cnt[j] - d[j], 1);
            chk(j, "beat_count", hs_cnt[j], exp_beats);
            chk(j, "read_count", rd_cnt[j], exp_words);
        end
    endtask

    task automatic fill_random(input int words);
        for (int a = 0; a < words; a++)
            mem[a] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int n;
        int q;
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        fill_random(256);

        repeat (3) tick();
        for (int j = 0; j < NI; j++) begin
            chk(j, "rst_ena", state_ena[j], 0);
            chk(j, "rst_wea", state_wea[j], 0);
            chk(j, "rst_addra", state_addra[j], 0);
            chk(j, "rst_valid", amp_valid[j], 0);
            chk(j, "rst_data", amp_data[j], 0);
            chk(j, "rst_addr", amp_addr[j], 0);
            chk(j, "rst_lane", amp_lane[j], 0);
            chk(j, "rst_last", amp_last[j], 0);
            chk(j, "rst_busy", busy[j], 0);
            chk(j, "rst_done", done[j], 0);
        end
        rst = 1'b0;
        repeat (2) tick();

        start_sweep(6'd2);  wait_done(200, 4, 1);
        start_sweep(6'd3);  wait_done(300, 8, 2);
        start_sweep(6'd0);  wait_done(200, 4, 1);
        start_sweep(6'd1);  wait_done(200, 4, 1);

        rand_rdy = 1;
        start_sweep(6'd4);  wait_done(2000, 16, 4);
        for (int r = 0; r < 4; r++) begin
            q = $urandom_range(0, 6);
            start_sweep(6'(q));
            wait_done(8000, words_of(q) * PE_NUM, words_of(q));
        end
        rand_rdy = 0;

        start_sweep(6'd4);
        repeat (10) tick();
        i_qbit_num = 6'd10;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(500, 16, 4);

        start_sweep(6'd4);
        n = 0;
        while (!amp_valid[0] && n < 50) begin tick(); n++; end
        chk(0, "reached_send", amp_valid[0], 1);
        rst = 1'b1;
        tick();
        for (int j = 0; j < NI; j++) begin
            chk(j, "abort_valid", amp_valid[j], 0);
            chk(j, "abort_busy", busy[j], 0);
            chk(j, "abort_done", done[j], 0);
        end
        rst = 1'b0;
        n = done_cnt[0] + done_cnt[1];
        repeat (30) tick();
        chk(0, "no_done_after_abort", done_cnt[0] + done_cnt[1], n);
        start_sweep(6'd2);  wait_done(200, 4, 1);

        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[0] = {64'h40000000_00000000, 192'h0};
        start_sweep(6'd10); wait_done(4000, 1024, 256);
        for (int j = 0; j < NI; j++) begin
            chk(j, "big_first_data", first_data[j], 64'h40000000_00000000);
            chk(j, "big_last_addr", last_hs_addr[j], 255);
            chk(j, "big_last_lane", last_hs_lane[j], 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/qea_state_reader.md
# qea_state_reader

Hardware readback engine for the QEA state RAM. It performs the read sweep that a host would otherwise drive by hand: it walks every state-RAM address through the QEA state port with the write enable low, and captures each PE_NUM-lane word. It then streams the word out one amplitude per beat on a valid/ready interface. It sits between QEA and the result sink (DMA or host bridge) and is started once QEA asserts o_complete.

## Interface
- PE_NUM_WIDTH, 2, log2 of lane count
- PE_NUM, 4, lanes (PEs) per state-RAM word
- DATA_WIDTH, 32, real/imag component width
- STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude {re,im}
- STATE_ADDR_WIDTH, 16, state-RAM address width
- MAX_QBIT_WIDTH, 6, width of qubit-count input
- RD_LATENCY, 1, state-RAM read latency in cycles (1..4)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; begins a sweep when idle
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled on accepted i_start
- o_state_ena  out  1  state-RAM port enable, tied to QEA i_state_ena
- o_state_wea  out  1  always 0 (read only), tied to QEA i_state_wea
- o_state_addra  out  STATE_ADDR_WIDTH  read address
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA o_state_dout
- o_amp_valid  out  1  amplitude beat valid
- i_amp_ready  in  1  sink ready
- o_amp_data  out  STATE_DATA_WIDTH  amplitude {re[63:32], im[31:0]}
- o_amp_addr  out  STATE_ADDR_WIDTH  RAM address of this beat
- o_amp_lane  out  PE_NUM_WIDTH  lane of this beat
- o_amp_last  out  1  final beat of sweep
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Word count N = 2^(qbit_num-2). If qbit_num<2, then N=1. If qbit_num-2 > STATE_ADDR_WIDTH, then N = 2^STATE_ADDR_WIDTH. N is latched at start.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE: an accepted i_start latches N, clears addr to 0 and goes to READ. i_start in any other state is ignored.
- READ: one cycle. o_state_ena=1, o_state_addra=addr. Then goes to WAIT.
- WAIT: counts RD_LATENCY cycles. On the last count it captures i_state_dout into a holding register, sets lane=0 and goes to SEND.
- SEND: o_amp_valid=1.
  - o_amp_data = holding register slice for the lane. Lane 0 is the MS slice [PE_NUM*64-1 -: 64]; lane k is the k-th slice from the top.
  - Each beat advances on valid&&ready.
  - After lane PE_NUM-1: if addr==N-1, go to DONE; otherwise addr+1 and go to READ.
- o_amp_last=1 only on lane PE_NUM-1 of addr N-1.
- DONE: o_done=1 for one cycle, then IDLE.
- The address counter is STATE_ADDR_WIDTH+1 bits internally, so N=2^STATE_ADDR_WIDTH terminates without wrap. o_state_addra uses the low bits.
- Holding register, addr and lane are stable while valid && !ready (AXI-style hold). Valid never drops without a handshake.

## Timing
- Reset values: o_state_ena=0, o_state_wea=0, o_state_addra=0, o_amp_valid=0, o_amp_data=0, o_amp_addr=0, o_amp_lane=0, o_amp_last=0, o_busy=0, o_done=0. FSM returns to IDLE.
- rst mid-sweep aborts on the next edge. No o_done, no further beats.
- i_start at cycle T: READ at T+1, capture at T+1+RD_LATENCY, first valid at T+2+RD_LATENCY.
- Per word: 1+RD_LATENCY overhead cycles plus PE_NUM beats. With ready tied high a full sweep takes N*(PE_NUM+1+RD_LATENCY) cycles, plus a 1-cycle DONE.
- o_busy=1 from the cycle after accepted i_start through the DONE cycle inclusive.
- o_state_wea is constant 0. This module never writes.

## Structure
- Shared package qea_pkg: DATA_WIDTH, STATE_DATA_WIDTH, PE_NUM and state-RAM width constants; reader FSM state enum.
- Optional sub-module qea_word_serializer: the holding register, lane counter and valid/ready hold logic.
- FSM, address counter and latency counter stay in the top.

## Test plan
- qbit_num=16, RAM preloaded with word0 = {64'h40000000_00000000, 0, 0, 0} and all other words zero, ready=1 -> 65536 beats. Beat 0: lane 0, addr 0, data 64'h40000000_00000000. All other data 0. Last beat: addr 16383, lane 3, with o_amp_last. o_done exactly once.
- qbit_num=2 -> exactly 4 beats at addr 0, lanes 0..3. o_amp_last on lane 3. Read enable pulsed exactly once.
- Random ready (50%), qbit_num=4 -> 16 beats in order. Data, addr and lane stable while stalled. No beat dropped or duplicated.
- i_start re-pulsed mid-sweep -> ignored; sweep count unchanged. i_qbit_num changed mid-sweep -> no effect.
- rst asserted during SEND -> next cycle o_amp_valid=0, o_busy=0 and no o_done. A new i_start then restarts from addr 0.
- RD_LATENCY=3, qbit_num=3 -> first valid 5 cycles after i_start. Each word's data matches the RAM contents at its addr.
